vga_mode_sequencer: RTL
=======================

Name: vga_mode_sequencer

Overview:
- Frame-synchronous controller for the test-pattern path. It sits between the board switches (BSW) and the image generator's mode input, in the pixel clock domain.
- It debounces the raw switch inputs and optionally auto-cycles through patterns.
- Every pattern change is applied only at a frame boundary, followed by a configurable number of muted frames so that no frame ever shows a torn mixed-pattern image.
- mute drives a forced-blanking override on the VGA data input.

Parameters:
MODE_WIDTH, 3, width of mode bus
NUM_MODES, 8, number of valid modes; legal codes are 0..NUM_MODES-1, with NUM_MODES <= 2**MODE_WIDTH
RESET_MODE, 0, mode_out value after reset
DEBOUNCE_CYCLES, 65536, consecutive clk cycles an input must be stable before it is accepted; >= 1
MUTE_FRAMES, 2, frames held muted after a mode change; 0 disables muting
AUTO_FRAMES, 120, frames per mode in auto-cycle; >= 1

Ports:
clk  input  1  pixel clock
rstn  input  1  asynchronous active-low reset
sw_mode  input  MODE_WIDTH  raw, asynchronous mode switches
auto_en_raw  input  1  raw, asynchronous auto-cycle enable switch
frame_end  input  1  one-cycle pulse on the last cycle of each frame
mode_out  output  MODE_WIDTH  registered mode to the image generator
mute  output  1  registered; 1 = force blanking colour
mode_changed  output  1  one-cycle pulse when a change completes (mute released)
busy  output  1  1 while in ARM or MUTE

Behaviour:
- Reset values (async assert, sync deassert handled upstream):
  - mode_out=RESET_MODE, mute=0, mode_changed=0, busy=0.
  - state=RUN.
  - Debounced vector = {0, RESET_MODE}. All counters = 0.
- Synchronisation: {auto_en_raw, sw_mode} passes through a 2-flop synchroniser per bit.
- Debounce (whole vector as one unit):
  - Counter resets to 0 whenever the synchronised vector differs from the candidate register; the candidate then takes the new value.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES-1.
  - On reaching DEBOUNCE_CYCLES-1, the debounced vector <= candidate.
  - Total latency from a raw edge to the debounced update: 2 sync + DEBOUNCE_CYCLES + 1 cycles.
- Target selection:
  - auto_en debounced = 0: target = debounced sw_mode.
  - auto_en debounced = 1: target = auto_mode.
  - A target value >= NUM_MODES is illegal and is treated as "no request" (target = mode_out).
- Auto-cycle:
  - auto_mode and the frame counter reset to the current mode_out and 0 whenever auto_en = 0.
  - In RUN with auto_en = 1, each frame_end increments the frame counter.
  - At AUTO_FRAMES-1, the counter clears and auto_mode <= (auto_mode+1) mod NUM_MODES, wrapping from NUM_MODES-1 to 0.
  - Counting is frozen in ARM and MUTE.
- State machine:
  - RUN:
    - If target != mode_out, go to ARM and set busy=1.
  - ARM:
    - Waits for frame_end. The target is re-evaluated every cycle, and the value on the frame_end cycle wins.
    - If target returns to mode_out before frame_end, go to RUN without any change.
    - On frame_end with MUTE_FRAMES > 0: mode_out <= target, mute <= 1, mute counter <= MUTE_FRAMES-1, go to MUTE.
    - On frame_end with MUTE_FRAMES = 0: mode_out <= target, mode_changed pulses the next cycle, go to RUN.
  - MUTE:
    - On frame_end: if the counter = 0, then mute <= 0, mode_changed=1 for one cycle, busy <= 0, go to RUN. Otherwise decrement the counter.
    - Target changes during MUTE are ignored. They are evaluated in RUN after release and start a new ARM.
- Timing of outputs:
  - mode_out and mute change in the cycle after the frame_end cycle, i.e. on the first pixel of the next frame.
  - mute is high for exactly MUTE_FRAMES full frames.
- Simultaneous events:
  - frame_end coincident with a debounced-value update: the updated target is used only from the next cycle.
  - frame_end coincident with entry to ARM (from RUN in the same cycle): it does not count. ARM waits for the following frame_end.
- Reset mid-operation: immediately returns to the reset values. Any pending change is discarded.
- frame_end stuck low: the FSM waits in ARM or MUTE indefinitely, with no timeout.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, MUTE_FRAMES=2, AUTO_FRAMES=3, NUM_MODES=6. frame_end every 100 cycles.
- Reset → mode_out=0, mute=0, busy=0. Then sw_mode=3 held steady → busy=1 at 2+4+1+1 cycles. At the next frame_end+1: mode_out=3, mute=1. mute stays high for 200 cycles. mode_changed pulses once, at the second subsequent frame_end+1.
- sw_mode glitches 0→5→0, each value lasting 2 cycles → no debounced change, busy stays 0, mode_out stays 0.
- In ARM, sw_mode changes 3→4, stable before frame_end → mode_out=4 (never 3). Change back to 0 before frame_end → returns to RUN, mute never asserted.
- sw_mode=7 (illegal, >= NUM_MODES) → no request, mode_out unchanged, busy=0.
- auto_en_raw=1 from mode 4 → after 3 frames target=5 and mode_out=5 after ARM and mute. Three frames after release, the mode wraps to 0.
- Assert rstn=0 while mute=1 → mode_out=0, mute=0, busy=0 in the same cycle, asynchronously.

Source files
------------

// File: rtl/vga_mode_sequencer.sv
// Frame-synchronous test-pattern mode sequencer: debounces the board switches,
// optionally auto-cycles patterns, and swaps modes only at frame boundaries behind muted frames.
//
// state | meaning
// RUN   | mode_out stable, watching for a target that differs from mode_out
// ARM   | change pending, waiting for the frame boundary to apply it
// MUTE  | new mode applied, output blanked until the mute frame count expires
module vga_mode_sequencer #(
  parameter int MODE_WIDTH      = 3,
  parameter int NUM_MODES       = 8,
  parameter int RESET_MODE      = 0,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int MUTE_FRAMES     = 2,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [MODE_WIDTH-1:0] sw_mode,
  input  logic                  auto_en_raw,
  input  logic                  frame_end,
  output logic [MODE_WIDTH-1:0] mode_out,
  output logic                  mute,
  output logic                  mode_changed,
  output logic                  busy
);

  localparam int VW   = MODE_WIDTH + 1;
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int MC_W = (MUTE_FRAMES > 1) ? $clog2(MUTE_FRAMES) : 1;
  localparam int AF_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  localparam logic [MODE_WIDTH-1:0] RESET_CODE = MODE_WIDTH'(RESET_MODE);
  localparam logic [MODE_WIDTH-1:0] LAST_CODE  = MODE_WIDTH'(NUM_MODES - 1);
  localparam logic [MODE_WIDTH:0]   NUM_CODES  = (MODE_WIDTH + 1)'(NUM_MODES);
  localparam logic [VW-1:0]         VEC_RESET  = {1'b0, RESET_CODE};
  localparam logic [DB_W-1:0]       DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AF_W-1:0]       AF_LAST    = AF_W'(AUTO_FRAMES - 1);
  localparam logic [MC_W-1:0]       MC_INIT    = MC_W'((MUTE_FRAMES > 0) ? MUTE_FRAMES - 1 : 0);
  localparam bit                    USE_MUTE   = (MUTE_FRAMES > 0);

  typedef enum logic [1:0] {S_RUN, S_ARM, S_MUTE} state_t;

  state_t                state;
  logic [VW-1:0]         sync_q1, sync_q2, cand, deb;
  logic [DB_W-1:0]       db_cnt;
  logic [MC_W-1:0]       mute_cnt;
  logic [AF_W-1:0]       frame_cnt;
  logic [MODE_WIDTH-1:0] auto_mode;
  logic [MODE_WIDTH-1:0] req;
  logic [MODE_WIDTH-1:0] target;
  logic                  auto_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q1 <= VEC_RESET;
      sync_q2 <= VEC_RESET;
    end else begin
      sync_q1 <= {auto_en_raw, sw_mode};
      sync_q2 <= sync_q1;
    end
  end

  // The switch vector is debounced as one unit so auto_en and mode settle together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cand   <= VEC_RESET;
      deb    <= VEC_RESET;
      db_cnt <= '0;
    end else if (sync_q2 != cand) begin
      cand   <= sync_q2;
      db_cnt <= '0;
    end else if (db_cnt != DB_LAST) begin
      db_cnt <= db_cnt + 1'b1;
    end else begin
      deb <= cand;
    end
  end

  assign auto_en = deb[MODE_WIDTH];

  // Out-of-range codes fall back to the current mode, i.e. no request.
  always_comb begin
    req    = auto_en ? auto_mode : deb[MODE_WIDTH-1:0];
    target = ({1'b0, req} < NUM_CODES) ? req : mode_out;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      auto_mode <= RESET_CODE;
      frame_cnt <= '0;
    end else if (!auto_en) begin
      auto_mode <= mode_out;
      frame_cnt <= '0;
    end else if (state == S_RUN && frame_end) begin
      if (frame_cnt == AF_LAST) begin
        frame_cnt <= '0;
        auto_mode <= (auto_mode == LAST_CODE) ? '0 : auto_mode + 1'b1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_RUN;
      mode_out     <= RESET_CODE;
      mute         <= 1'b0;
      mode_changed <= 1'b0;
      busy         <= 1'b0;
      mute_cnt     <= '0;
    end else begin
      mode_changed <= 1'b0;
      case (state)
        S_RUN: begin
          // A frame_end in this cycle is deliberately ignored; ARM waits for the next one.
          if (target != mode_out) begin
            state <= S_ARM;
            busy  <= 1'b1;
          end
        end
        S_ARM: begin
          if (target == mode_out) begin
            state <= S_RUN;
            busy  <= 1'b0;
          end else if (frame_end) begin
            mode_out <= target;
            if (USE_MUTE) begin
              mute     <= 1'b1;
              mute_cnt <= MC_INIT;
              state    <= S_MUTE;
            end else begin
              mode_changed <= 1'b1;
              busy         <= 1'b0;
              state        <= S_RUN;
            end
          end
        end
        S_MUTE: begin
          if (frame_end) begin
            if (mute_cnt == '0) begin
              mute         <= 1'b0;
              mode_changed <= 1'b1;
              busy         <= 1'b0;
              state        <= S_RUN;
            end else begin
              mute_cnt <= mute_cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= S_RUN;
          mute  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
